// File: rtl/hpi_target_model_if.sv
// Host port interface bundle: the host drives address/data/strobes and the target answers with read data and irq.
interface hpi_target_model_if;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic        hpi_cs_n;
    logic        hpi_rst_n;
    logic        hpi_irq;

    modport master (
        output hpi_addr, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n,
        input  hpi_data_out, hpi_irq
    );

    modport slave (
        input  hpi_addr, hpi_data_in, hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n,
        output hpi_data_out, hpi_irq
    );
endinterface

// File: rtl/hpi_target_model.sv
// HPI target stand-in: word RAM window, auto-incrementing pointer, two mailboxes, status register.
// Optional protocol checker enabled by defining HPI_PROTO_CHECK_EN; otherwise proto_err is tied low.
module hpi_target_model #(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    hpi_target_model_if.slave   hpi,
    output logic [15:0]         mbx_rx_data,
    output logic                mbx_rx_valid,
    input  logic                mbx_rx_ack,
    input  logic [15:0]         mbx_tx_data,
    input  logic                mbx_tx_wr,
    output logic                proto_err
);

    // state  | meaning
    // S_IDLE  | no read pending, a read START is accepted
    // S_WAIT  | read source captured, counting down extra latency cycles
    // S_DRIVE | load captured read value onto hpi_data_out
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [1:0]  A_DATA   = 2'd0;
    localparam logic [1:0]  A_MBX    = 2'd1;
    localparam logic [1:0]  A_ADDR   = 2'd2;
    localparam logic [1:0]  A_STAT   = 2'd3;
    localparam logic [2:0]  WAIT_CNT = (RD_LAT > 3) ? 3'(RD_LAT - 3) : 3'd0;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] rd_buf_q;
    logic [15:0] data_out_q;
    logic [15:0] mem_q [DEPTH];

    logic        active_q, active_d;
    logic [1:0]  acc_addr_q, acc_addr_d;
    logic        acc_rd_q, acc_rd_d;
    logic        acc_ok_q, acc_ok_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_full_q, tx_full_d;

    logic          active, start, fin, rd_start, wr_start;
    logic [AW-1:0] idx;
    logic [15:0]   rd_src;

    assign active   = !hpi.hpi_cs_n && (!hpi.hpi_r_n ^ !hpi.hpi_w_n);
    assign start    = active && !active_q;
    assign fin      = !active && active_q;
    assign rd_start = start && !hpi.hpi_r_n && (state_q == S_IDLE);
    assign wr_start = start && !hpi.hpi_w_n;
    // Byte-style pointer: bit 0 ignored, upper bits alias modulo DEPTH.
    assign idx      = addr_q[AW:1];

    always_comb begin
        rd_src = 16'h0000;
        case (hpi.hpi_addr)
            A_DATA:  rd_src = mem_q[idx];
            A_MBX:   rd_src = tx_data_q;
            A_ADDR:  rd_src = addr_q;
            A_STAT:  rd_src = {14'b0, tx_full_q, rx_valid_q};
            default: rd_src = 16'h0000;
        endcase
    end

    always_comb begin
        active_d   = active;
        acc_addr_d = acc_addr_q;
        acc_rd_d   = acc_rd_q;
        acc_ok_d   = acc_ok_q;
        addr_d     = addr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_data_d  = tx_data_q;
        tx_full_d  = tx_full_q;

        if (start) begin
            acc_addr_d = hpi.hpi_addr;
            acc_rd_d   = !hpi.hpi_r_n;
            acc_ok_d   = wr_start || rd_start;
        end

        if (wr_start && hpi.hpi_addr == A_ADDR)
            addr_d = hpi.hpi_data_in;
        if (fin && acc_ok_q && acc_addr_q == A_DATA)
            addr_d = addr_q + 16'd2;

        // Host mailbox write beats a coincident local ack.
        if (mbx_rx_ack)
            rx_valid_d = 1'b0;
        if (wr_start && hpi.hpi_addr == A_MBX) begin
            rx_data_d  = hpi.hpi_data_in;
            rx_valid_d = 1'b1;
        end

        // Local load beats a coincident host mailbox read END.
        if (fin && acc_ok_q && acc_rd_q && acc_addr_q == A_MBX)
            tx_full_d = 1'b0;
        if (mbx_tx_wr) begin
            tx_data_d = mbx_tx_data;
            tx_full_d = 1'b1;
        end

        if (!hpi.hpi_rst_n) begin
            active_d   = 1'b0;
            acc_addr_d = 2'd0;
            acc_rd_d   = 1'b0;
            acc_ok_d   = 1'b0;
            addr_d     = 16'h0000;
            rx_data_d  = 16'h0000;
            rx_valid_d = 1'b0;
            tx_data_d  = 16'h0000;
            tx_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            active_q   <= 1'b0;
            acc_addr_q <= 2'd0;
            acc_rd_q   <= 1'b0;
            acc_ok_q   <= 1'b0;
            addr_q     <= 16'h0000;
            rx_data_q  <= 16'h0000;
            rx_valid_q <= 1'b0;
            tx_data_q  <= 16'h0000;
            tx_full_q  <= 1'b0;
        end else begin
            active_q   <= active_d;
            acc_addr_q <= acc_addr_d;
            acc_rd_q   <= acc_rd_d;
            acc_ok_q   <= acc_ok_d;
            addr_q     <= addr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_full_q  <= tx_full_d;
        end
    end

    // RAM contents deliberately survive both resets.
    always_ff @(posedge clk_clk) begin
        if (wr_start && hpi.hpi_addr == A_DATA && hpi.hpi_rst_n)
            mem_q[idx] <= hpi.hpi_data_in;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            rd_buf_q   <= 16'h0000;
            data_out_q <= 16'h0000;
        end else if (!hpi.hpi_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            rd_buf_q   <= 16'h0000;
            data_out_q <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_start) begin
                        rd_buf_q <= rd_src;
                        if (RD_LAT <= 1) begin
                            data_out_q <= rd_src;
                        end else if (RD_LAT == 2) begin
                            state_q <= S_DRIVE;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_CNT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0)
                        state_q <= S_DRIVE;
                    else
                        cnt_q <= cnt_q - 3'd1;
                end
                S_DRIVE: begin
                    data_out_q <= rd_buf_q;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hpi.hpi_data_out = data_out_q;
    assign hpi.hpi_irq      = tx_full_q;
    assign mbx_rx_data      = rx_data_q;
    assign mbx_rx_valid     = rx_valid_q;

`ifdef HPI_PROTO_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (!hpi.hpi_cs_n && !hpi.hpi_r_n && !hpi.hpi_w_n)
            perr_d = 1'b1;
        if (active && active_q && hpi.hpi_addr != acc_addr_q)
            perr_d = 1'b1;
        if (!hpi.hpi_rst_n)
            perr_d = 1'b0;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            perr_q <= 1'b0;
        else
            perr_q <= perr_d;
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_target_model.sv
// Self-checking bench for hpi_target_model: vector table, directed corner sequences, random ops vs a transaction model.
module tb_hpi_target_model;
    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 2;
    localparam logic [1:0] R_DATA = 2'd0, R_MBX = 2'd1, R_ADDR = 2'd2, R_STAT = 2'd3;
`ifdef HPI_PROTO_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mbx_rx_data;
    logic        mbx_rx_valid;
    logic        mbx_rx_ack = 1'b0;
    logic [15:0] mbx_tx_data = 16'h0000;
    logic        mbx_tx_wr = 1'b0;
    logic        proto_err;

    hpi_target_model_if hpi ();

    hpi_target_model #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .hpi          (hpi),
        .mbx_rx_data  (mbx_rx_data),
        .mbx_rx_valid (mbx_rx_valid),
        .mbx_rx_ack   (mbx_rx_ack),
        .mbx_tx_data  (mbx_tx_data),
        .mbx_tx_wr    (mbx_tx_wr),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [20];

    // Transaction-level reference model.
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_addr, m_rx, m_tx;
    logic        m_rxv, m_txf;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        hpi.hpi_cs_n = 1'b1;
        hpi.hpi_r_n  = 1'b1;
        hpi.hpi_w_n  = 1'b1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        hpi.hpi_addr    = a;
        hpi.hpi_data_in = d;
        hpi.hpi_cs_n    = 1'b0;
        hpi.hpi_w_n     = 1'b0;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic host_read(input logic [1:0] a, output logic [15:0] early, output logic [15:0] v);
        early        = hpi.hpi_data_out;
        hpi.hpi_addr = a;
        hpi.hpi_cs_n = 1'b0;
        hpi.hpi_r_n  = 1'b0;
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            if (k == RD_LAT - 1) early = hpi.hpi_data_out;
            if (k == 1) bus_idle();
        end
        v = hpi.hpi_data_out;
        if (RD_LAT < 2) @(negedge clk);
    endtask

    task automatic tx_load(input logic [15:0] v);
        mbx_tx_data = v;
        mbx_tx_wr   = 1'b1;
        @(negedge clk);
        mbx_tx_wr   = 1'b0;
    endtask

    task automatic rx_ack_pulse();
        mbx_rx_ack = 1'b1;
        @(negedge clk);
        mbx_rx_ack = 1'b0;
    endtask

    task automatic soft_reset();
        hpi.hpi_rst_n = 1'b0;
        @(negedge clk);
        hpi.hpi_rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic int idx_of(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] e, v, prev, dbefore;

        hpi.hpi_addr    = 2'd0;
        hpi.hpi_data_in = 16'h0000;
        hpi.hpi_rst_n   = 1'b1;
        bus_idle();

        tbl[0]  = '{1'b1, R_ADDR, 16'h0010, 16'h0000};
        tbl[1]  = '{1'b1, R_DATA, 16'hA5A5, 16'h0000};
        tbl[2]  = '{1'b1, R_DATA, 16'h5A5A, 16'h0000};
        tbl[3]  = '{1'b1, R_ADDR, 16'h0010, 16'h0000};
        tbl[4]  = '{1'b0, R_DATA, 16'h0000, 16'hA5A5};
        tbl[5]  = '{1'b0, R_DATA, 16'h0000, 16'h5A5A};
        tbl[6]  = '{1'b0, R_ADDR, 16'h0000, 16'h0014};
        tbl[7]  = '{1'b1, R_ADDR, 16'h07FE, 16'h0000};
        tbl[8]  = '{1'b1, R_DATA, 16'h1234, 16'h0000};
        tbl[9]  = '{1'b1, R_DATA, 16'hBEEF, 16'h0000};
        tbl[10] = '{1'b1, R_ADDR, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, R_DATA, 16'h0000, 16'hBEEF};
        tbl[12] = '{1'b0, R_ADDR, 16'h0000, 16'h0002};
        tbl[13] = '{1'b1, R_ADDR, 16'hFFFE, 16'h0000};
        tbl[14] = '{1'b1, R_DATA, 16'h7777, 16'h0000};
        tbl[15] = '{1'b0, R_ADDR, 16'h0000, 16'h0000};
        tbl[16] = '{1'b1, R_ADDR, 16'h07FE, 16'h0000};
        tbl[17] = '{1'b0, R_DATA, 16'h0000, 16'h7777};
        tbl[18] = '{1'b1, R_STAT, 16'hFFFF, 16'h0000};
        tbl[19] = '{1'b0, R_STAT, 16'h0000, 16'h0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_data_out", hpi.hpi_data_out, 16'h0000);
        check("rst_irq", {15'b0, hpi.hpi_irq}, 16'h0000);
        check("rst_rx_valid", {15'b0, mbx_rx_valid}, 16'h0000);
        check("rst_rx_data", mbx_rx_data, 16'h0000);
        check("rst_proto_err", {15'b0, proto_err}, 16'h0000);
        host_read(R_ADDR, e, v);
        check("rst_addr_reg", v, 16'h0000);
        host_read(R_STAT, e, v);
        check("rst_status", v, 16'h0000);

        prev = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].wr) begin
                host_write(tbl[i].a, tbl[i].d);
            end else begin
                host_read(tbl[i].a, e, v);
                check($sformatf("tbl[%0d]_read", i), v, tbl[i].exp);
                check($sformatf("tbl[%0d]_latency_hold", i), e, prev);
                prev = tbl[i].exp;
            end
        end

        // Host -> local mailbox, including write racing an ack.
        host_write(R_MBX, 16'hCAFE);
        check("mbx_rx_valid_set", {15'b0, mbx_rx_valid}, 16'h0001);
        check("mbx_rx_data", mbx_rx_data, 16'hCAFE);
        host_read(R_STAT, e, v);
        check("status_rx_full", v, 16'h0001);
        rx_ack_pulse();
        check("mbx_rx_valid_ack", {15'b0, mbx_rx_valid}, 16'h0000);
        host_read(R_STAT, e, v);
        check("status_rx_empty", v, 16'h0000);
        hpi.hpi_addr = R_MBX; hpi.hpi_data_in = 16'hBEAD;
        hpi.hpi_cs_n = 1'b0; hpi.hpi_w_n = 1'b0; mbx_rx_ack = 1'b1;
        @(negedge clk);
        bus_idle(); mbx_rx_ack = 1'b0;
        check("mbx_ack_race_valid", {15'b0, mbx_rx_valid}, 16'h0001);
        check("mbx_ack_race_data", mbx_rx_data, 16'hBEAD);
        @(negedge clk);
        rx_ack_pulse();

        // Local -> host mailbox, including load racing the read END.
        tx_load(16'h0042);
        check("tx_irq_set", {15'b0, hpi.hpi_irq}, 16'h0001);
        host_read(R_STAT, e, v);
        check("status_tx_full", v, 16'h0002);
        host_read(R_MBX, e, v);
        check("tx_mbx_read", v, 16'h0042);
        check("tx_irq_clr", {15'b0, hpi.hpi_irq}, 16'h0000);
        tx_load(16'h0043);
        hpi.hpi_addr = R_MBX; hpi.hpi_cs_n = 1'b0; hpi.hpi_r_n = 1'b0;
        @(negedge clk);
        bus_idle(); mbx_tx_data = 16'h0099; mbx_tx_wr = 1'b1;
        @(negedge clk);
        mbx_tx_wr = 1'b0;
        for (int k = 2; k < RD_LAT; k++) @(negedge clk);
        check("tx_race_read", hpi.hpi_data_out, 16'h0043);
        check("tx_race_irq", {15'b0, hpi.hpi_irq}, 16'h0001);
        host_read(R_MBX, e, v);
        check("tx_race_new_word", v, 16'h0099);
        check("tx_race_irq_clr", {15'b0, hpi.hpi_irq}, 16'h0000);

        // Soft reset in the middle of a pending read.
        host_write(R_MBX, 16'h1111);
        tx_load(16'h2222);
        host_write(R_ADDR, 16'h0010);
        hpi.hpi_addr = R_DATA; hpi.hpi_cs_n = 1'b0; hpi.hpi_r_n = 1'b0;
        @(negedge clk);
        bus_idle(); hpi.hpi_rst_n = 1'b0;
        @(negedge clk);
        hpi.hpi_rst_n = 1'b1;
        check("srst_data_out", hpi.hpi_data_out, 16'h0000);
        check("srst_irq", {15'b0, hpi.hpi_irq}, 16'h0000);
        check("srst_rx_valid", {15'b0, mbx_rx_valid}, 16'h0000);
        check("srst_rx_data", mbx_rx_data, 16'h0000);
        repeat (RD_LAT + 1) @(negedge clk);
        check("srst_read_dropped", hpi.hpi_data_out, 16'h0000);
        host_read(R_ADDR, e, v);
        check("srst_addr_reg", v, 16'h0000);
        host_read(R_MBX, e, v);
        check("srst_tx_mbx", v, 16'h0000);
        host_write(R_ADDR, 16'h0010);
        host_read(R_DATA, e, v);
        check("srst_ram_kept0", v, 16'hA5A5);
        host_read(R_DATA, e, v);
        check("srst_ram_kept1", v, 16'h5A5A);

        // Both strobes low: no access.
        host_write(R_ADDR, 16'h0010);
        dbefore = hpi.hpi_data_out;
        hpi.hpi_addr = R_DATA; hpi.hpi_data_in = 16'hFFFF;
        hpi.hpi_cs_n = 1'b0; hpi.hpi_r_n = 1'b0; hpi.hpi_w_n = 1'b0;
        repeat (2) @(negedge clk);
        hpi.hpi_addr = R_MBX;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        check("both_low_rx_valid", {15'b0, mbx_rx_valid}, 16'h0000);
        check("both_low_data_out", hpi.hpi_data_out, dbefore);
        check("both_low_proto_err", {15'b0, proto_err}, {15'b0, PERR_EXP});
        host_read(R_ADDR, e, v);
        check("both_low_addr", v, 16'h0010);
        host_read(R_DATA, e, v);
        check("both_low_ram", v, 16'hA5A5);

        // Address change during an active strobe.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_proto_err_clr", {15'b0, proto_err}, 16'h0000);
        hpi.hpi_addr = R_ADDR; hpi.hpi_cs_n = 1'b0; hpi.hpi_r_n = 1'b0;
        @(negedge clk);
        hpi.hpi_addr = R_STAT;
        @(negedge clk);
        bus_idle();
        repeat (RD_LAT) @(negedge clk);
        check("addr_change_proto_err", {15'b0, proto_err}, {15'b0, PERR_EXP});

        // Randomized phase against the transaction model.
        soft_reset();
        m_addr = 16'h0000; m_rx = 16'h0000; m_tx = 16'h0000; m_rxv = 1'b0; m_txf = 1'b0;
        host_write(R_ADDR, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            v = 16'($urandom);
            host_write(R_DATA, v);
            m_mem[idx_of(m_addr)] = v;
            m_addr = m_addr + 16'd2;
        end
        host_read(R_ADDR, e, v);
        check("fill_addr", v, m_addr);

        for (int i = 0; i < 300; i++) begin
            int op;
            logic [1:0]  r;
            logic [15:0] d, exp;
            op = $urandom_range(0, 6);
            d  = 16'($urandom);
            r  = 2'($urandom_range(0, 3));
            case (op)
                0: begin host_write(R_ADDR, d); m_addr = d; end
                1: begin
                    host_write(R_DATA, d);
                    m_mem[idx_of(m_addr)] = d;
                    m_addr = m_addr + 16'd2;
                end
                2: begin host_write(R_MBX, d); m_rx = d; m_rxv = 1'b1; end
                3: begin
                    case (r)
                        R_DATA:  exp = m_mem[idx_of(m_addr)];
                        R_MBX:   exp = m_tx;
                        R_ADDR:  exp = m_addr;
                        default: exp = {14'b0, m_txf, m_rxv};
                    endcase
                    host_read(r, e, v);
                    check($sformatf("rnd[%0d]_read_reg%0d", i, r), v, exp);
                    if (r == R_DATA) m_addr = m_addr + 16'd2;
                    if (r == R_MBX)  m_txf = 1'b0;
                end
                4: begin tx_load(d); m_tx = d; m_txf = 1'b1; end
                5: begin rx_ack_pulse(); m_rxv = 1'b0; end
                default: host_write(R_STAT, d);
            endcase
            check($sformatf("rnd[%0d]_irq", i), {15'b0, hpi.hpi_irq}, {15'b0, m_txf});
            check($sformatf("rnd[%0d]_rx_valid", i), {15'b0, mbx_rx_valid}, {15'b0, m_rxv});
            check($sformatf("rnd[%0d]_rx_data", i), mbx_rx_data, m_rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
